// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S playback sample FIFO.
package i2s_pkg;

  localparam int unsigned I2S_FIFO_DEPTH_DEFAULT = 16;
  localparam logic [31:0] SILENCE_WORD           = 32'd0;

  typedef struct packed {
    logic full;
    logic empty;
    logic overflow;
    logic underflow;
  } i2s_fifo_status_t;

endpackage

// File: rtl/i2s_sample_fifo_if.sv
// Bus/transmitter-side signal bundle for the I2S sample FIFO.
// master: CPU writer plus I2S transmitter; slave: the FIFO itself.
interface i2s_sample_fifo_if
  import i2s_pkg::*;
#(
  parameter int unsigned DEPTH = I2S_FIFO_DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
);

  logic          flush;
  logic          writeEnable;
  logic [31:0]   writeData;
  logic          readReq;
  logic [31:0]   sampleData;
  logic [AW:0]   threshold;
  logic          clearFlags;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;
  logic          irq;

  modport master (
    output flush, writeEnable, writeData, readReq, threshold, clearFlags,
    input  sampleData, level, full, empty, overflow, underflow, irq
  );

  modport slave (
    input  flush, writeEnable, writeData, readReq, threshold, clearFlags,
    output sampleData, level, full, empty, overflow, underflow, irq
  );

endinterface

// File: rtl/sample_fifo_ram.sv
// DEPTH x 32 sample storage: one synchronous write port, one asynchronous read port.
module sample_fifo_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/i2s_sample_fifo.sv
// Show-ahead playback FIFO feeding the I2S transmitter, with sticky status flags.
// Define I2S_SAMPLE_FIFO_IRQ_EN to build the registered low-watermark refill irq.
module i2s_sample_fifo
  import i2s_pkg::*;
#(
  parameter int unsigned DEPTH = I2S_FIFO_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  i2s_sample_fifo_if.slave  bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] LevelMax = (AW + 1)'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          push_ok, pop_ok, ovf_set, unf_set, ram_we;
  logic [31:0]   ram_rdata;
  i2s_fifo_status_t status;

  assign status.full      = (level_q == LevelMax);
  assign status.empty     = (level_q == '0);
  assign status.overflow  = ovf_q;
  assign status.underflow = unf_q;

  always_comb begin
    // A pop while full frees the slot the concurrent push needs.
    push_ok = bus.writeEnable && (!status.full || bus.readReq);
    pop_ok  = bus.readReq && !status.empty;
    ovf_set = !bus.flush && bus.writeEnable && status.full && !bus.readReq;
    unf_set = !bus.flush && bus.readReq && status.empty;
    ram_we  = !bus.flush && push_ok;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      level_d = level_q + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
    end

    ovf_d = ovf_set ? 1'b1 : (bus.clearFlags ? 1'b0 : ovf_q);
    unf_d = unf_set ? 1'b1 : (bus.clearFlags ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  sample_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (wptr_q),
    .wdata_i (bus.writeData),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  assign bus.sampleData = status.empty ? SILENCE_WORD : ram_rdata;
  assign bus.level      = level_q;
  assign bus.full       = status.full;
  assign bus.empty      = status.empty;
  assign bus.overflow   = status.overflow;
  assign bus.underflow  = status.underflow;

`ifdef I2S_SAMPLE_FIFO_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = (level_d <= bus.threshold) || unf_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.irq = irq_q;
`else
  logic unused_threshold;
  assign unused_threshold = ^bus.threshold;
  assign bus.irq          = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Directed bench for i2s_sample_fifo: queue-based reference model checked every cycle,
// plus literal expectations along the directed sequence.
module tb_i2s_sample_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

`ifdef I2S_SAMPLE_FIFO_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 1'b0;

  i2s_sample_fifo_if #(.DEPTH(DEPTH)) bus ();

  i2s_sample_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue holding the stored words plus the sticky flags.
  logic [31:0] mq[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;
  bit          m_irq = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_irq = 1'b0;
    end else begin
      bit ovf_ev, unf_ev, can_push, can_pop;
      ovf_ev = 1'b0;
      unf_ev = 1'b0;
      if (bus.flush) begin
        mq.delete();
      end else begin
        can_pop  = bus.readReq && (mq.size() > 0);
        can_push = bus.writeEnable && ((mq.size() < DEPTH) || bus.readReq);
        ovf_ev   = bus.writeEnable && !can_push;
        unf_ev   = bus.readReq && (mq.size() == 0);
        if (can_pop)  void'(mq.pop_front());
        if (can_push) mq.push_back(bus.writeData);
      end
      if (ovf_ev) m_ovf = 1'b1;
      else if (bus.clearFlags) m_ovf = 1'b0;
      if (unf_ev) m_unf = 1'b1;
      else if (bus.clearFlags) m_unf = 1'b0;
      m_irq = IrqEn && ((mq.size() <= int'(bus.threshold)) || m_unf);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m.sampleData", bus.sampleData, (mq.size() > 0) ? mq[0] : 32'd0);
      check("m.level", 32'(bus.level), 32'(mq.size()));
      check("m.full", 32'(bus.full), 32'(mq.size() == DEPTH));
      check("m.empty", 32'(bus.empty), 32'(mq.size() == 0));
      check("m.overflow", 32'(bus.overflow), 32'(m_ovf));
      check("m.underflow", 32'(bus.underflow), 32'(m_unf));
      check("m.irq", 32'(bus.irq), 32'(m_irq));
    end
  end

  task automatic step(input logic we, input logic [31:0] wd, input logic rd,
                      input logic clr, input logic fl);
    bus.writeEnable = we;
    bus.writeData   = wd;
    bus.readReq     = rd;
    bus.clearFlags  = clr;
    bus.flush       = fl;
    @(negedge clk);
    bus.writeEnable = 1'b0;
    bus.readReq     = 1'b0;
    bus.clearFlags  = 1'b0;
    bus.flush       = 1'b0;
  endtask

  initial begin
    reset           = 1'b0;
    bus.flush       = 1'b0;
    bus.writeEnable = 1'b0;
    bus.writeData   = 32'd0;
    bus.readReq     = 1'b0;
    bus.clearFlags  = 1'b0;
    bus.threshold   = (AW + 1)'(4);
    repeat (2) @(negedge clk);

    // 1: reset state
    check("rst.empty", 32'(bus.empty), 32'd1);
    check("rst.level", 32'(bus.level), 32'd0);
    check("rst.sampleData", bus.sampleData, 32'd0);
    check("rst.irq", 32'(bus.irq), 32'd0);
    reset  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst.irq_after_edge", 32'(bus.irq), IrqEn ? 32'd1 : 32'd0);

    // 2: two pushes, two pops
    step(1'b1, 32'hAAAA5555, 1'b0, 1'b0, 1'b0);
    check("t2.first", bus.sampleData, 32'hAAAA5555);
    check("t2.empty", 32'(bus.empty), 32'd0);
    step(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0);
    check("t2.level2", 32'(bus.level), 32'd2);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("t2.second", bus.sampleData, 32'h12345678);
    check("t2.level1", 32'(bus.level), 32'd1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("t2.silence", bus.sampleData, 32'd0);
    check("t2.level0", 32'(bus.level), 32'd0);
    check("t2.underflow", 32'(bus.underflow), 32'd0);

    // 3: overfill by one, then drain across the pointer wrap
    for (int k = 1; k <= 17; k++) step(1'b1, 32'h1000_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
    check("t3.full", 32'(bus.full), 32'd1);
    check("t3.level", 32'(bus.level), 32'd16);
    check("t3.overflow", 32'(bus.overflow), 32'd1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("t3.ovf_cleared", 32'(bus.overflow), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      check("t3.order", bus.sampleData, 32'h1000_0000 + 32'(k));
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    end
    check("t3.drained", 32'(bus.empty), 32'd1);

    // 4: push and pop together while full
    for (int k = 1; k <= 16; k++) step(1'b1, 32'h2000_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
    check("t4.level", 32'(bus.level), 32'd16);
    check("t4.overflow", 32'(bus.overflow), 32'd0);
    check("t4.head", bus.sampleData, 32'h2000_0002);
    for (int k = 0; k < 15; k++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("t4.new_word", bus.sampleData, 32'hCAFEF00D);
    check("t4.level1", 32'(bus.level), 32'd1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // 5: underflow and clear-vs-set priority
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("t5.underflow", 32'(bus.underflow), 32'd1);
    check("t5.silence", bus.sampleData, 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    check("t5.set_wins", 32'(bus.underflow), 32'd1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("t5.cleared", 32'(bus.underflow), 32'd0);

    // 6: flush beats a push and keeps flags; then asynchronous reset mid-stream
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) step(1'b1, 32'h3000_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
    check("t6.level5", 32'(bus.level), 32'd5);
    check("t6.irq_above", 32'(bus.irq), IrqEn ? 32'd1 : 32'd0);
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    check("t6.flush_level", 32'(bus.level), 32'd0);
    check("t6.flush_empty", 32'(bus.empty), 32'd1);
    check("t6.flags_kept", 32'(bus.underflow), 32'd1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) step(1'b1, 32'h4000_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
    check("t6.irq_cleared", 32'(bus.irq), 32'd0);
    check("t6.pre_reset", bus.sampleData, 32'h4000_0001);
    #2 reset = 1'b0;
    #1;
    check("t6.ar_level", 32'(bus.level), 32'd0);
    check("t6.ar_empty", 32'(bus.empty), 32'd1);
    check("t6.ar_full", 32'(bus.full), 32'd0);
    check("t6.ar_data", bus.sampleData, 32'd0);
    check("t6.ar_ovf", 32'(bus.overflow), 32'd0);
    check("t6.ar_unf", 32'(bus.underflow), 32'd0);
    check("t6.ar_irq", 32'(bus.irq), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    step(1'b1, 32'h5555AAAA, 1'b0, 1'b0, 1'b0);
    check("t6.after_reset", bus.sampleData, 32'h5555AAAA);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_sample_fifo.md
Name: i2s_sample_fifo

Overview:
Playback sample buffer that sits directly upstream of the I2S slave transmitter.
- Accepts 32-bit packed sample words from the CPU/bus side.
- Presents the head word on sampleData, show-ahead.
- Advances to the next word on the transmitter's single-cycle readReq pulse.
- Reports level, full/empty and sticky overflow/underflow status, plus a low-watermark refill interrupt.

Parameters:
DEPTH, 16, number of 32-bit words stored; power of two, 4..256.
AW, $clog2(DEPTH), pointer width; the level field is AW+1 bits.

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  asynchronous, active-low reset (asserted at 0).
flush  input  1  synchronous clear of contents and pointers.
writeEnable  input  1  push writeData this cycle.
writeData  input  32  packed sample word; upper half/byte is played first.
readReq  input  1  single-cycle pop strobe from the transmitter.
sampleData  output  32  head word; 0 when empty.
threshold  input  AW+1  low-watermark level for irq.
clearFlags  input  1  clears the sticky overflow/underflow flags.
level  output  AW+1  current word count, 0..DEPTH.
full  output  1  level == DEPTH.
empty  output  1  level == 0.
overflow  output  1  sticky: a push was attempted while full.
underflow  output  1  sticky: a pop was attempted while empty.
irq  output  1  refill request, level-sensitive.

Behaviour:
Reset (reset == 0):
- Pointers = 0, level = 0, empty = 1, full = 0, sampleData = 0.
- overflow = underflow = 0, irq = 0.
- Storage contents are not reset.

Storage and pointers:
- Circular buffer; writePtr and readPtr are AW bits and wrap modulo DEPTH.
- level is a separate AW+1-bit counter. full/empty are decoded from level.
- sampleData = mem[readPtr] when level != 0, else 32'd0 (silence). Decode is combinational from registered state.

Push:
- writeEnable && !full → mem[writePtr] = writeData, writePtr+1.
- writeEnable && full → word dropped, overflow set. Pointers are unchanged.

Pop:
- readReq && !empty → readPtr+1.
- readReq && empty → no pointer change, underflow set.

Simultaneous push and pop:
- Not empty and not full: both happen, level unchanged.
- Empty: push succeeds, the pop is treated as underflow, level becomes 1.
- Full: the pop frees a slot, so the push is accepted, level stays DEPTH, no overflow.

Latency:
- A word pushed into an empty FIFO at edge N appears on sampleData after edge N; empty deasserts at the same edge.
- After a pop, the next word is on sampleData one cycle later.

flush:
- Highest priority. Pointers and level go to 0; a push or pop in the same cycle is ignored.
- Sticky flags are not cleared.

clearFlags:
- Clears overflow/underflow.
- A set event in the same cycle wins (flag stays 1).

readReq held for multiple cycles: one pop per cycle (the transmitter only ever pulses it).

Optional Feature:
Macro I2S_SAMPLE_FIFO_IRQ_EN.
- Defined: irq is a register.
  - irq = 1 when level <= threshold, or when underflow = 1.
  - Updated on every clk edge from next-state values.
  - Cleared only by the level rising above threshold and underflow being cleared.
- Not defined: irq is tied to 0, the threshold input is ignored, and no comparator logic is generated.
- Port list is identical in both builds.

Decomposition:
Package i2s_pkg:
- I2S_FIFO_DEPTH_DEFAULT constant.
- i2s_fifo_status_t typedef: packed struct {full, empty, overflow, underflow}.
- SILENCE_WORD = 32'd0.

Sub-module sample_fifo_ram:
- DEPTH x 32 register array with one write port and one async read port.
- The top level keeps the pointers, level, flags and irq.

Test Plan:
1. Reset low, then high → empty = 1, level = 0, sampleData = 0, irq = 1 (IRQ_EN, threshold = 4).
2. Push 0xAAAA5555, 0x12345678, then pulse readReq twice → sampleData = 0xAAAA5555, then 0x12345678, then 0; level 2 → 1 → 0; underflow stays 0.
3. Push 17 words with DEPTH = 16 → full = 1, level = 16, overflow = 1; 16 pops return words 1..16 in order, across pointer wrap.
4. Full FIFO, writeEnable and readReq in the same cycle → level stays 16, overflow stays 0, the new word is read after 15 more pops.
5. Empty FIFO, readReq → underflow = 1, sampleData = 0; clearFlags and readReq in the same cycle → underflow stays 1; clearFlags alone → 0.
6. Level 5 with a flush and a push in the same cycle → level = 0, empty = 1, flags preserved; reset pulsed low mid-stream → all outputs return to reset values asynchronously.
